// File: rtl/mipi_pkg.sv
// mipi_pkg: shared CSI-2 data type codes, byte type and accumulator depth
package mipi_pkg;
   localparam logic [5:0] DT_RAW8 = 6'h2A;
   localparam logic [5:0] DT_RAW10 = 6'h2B;
   localparam int ACC_BYTES = 8;
   typedef logic [7:0] byte_t;
endpackage

// File: rtl/raw10_decode.sv
// raw10_decode: unpacks one RAW10 5-byte group into four 10-bit pixels
module raw10_decode (
   input  logic [39:0] bytes,
   output logic [39:0] pix
);
   for (genvar i = 0; i < 4; i++) begin : g_pix
      assign pix[10*i +: 10] = {bytes[8*i +: 8], bytes[32 + 2*i +: 2]};
   end
endmodule

// File: rtl/raw_unpacker.sv
// raw_unpacker: CSI-2 RAW8/RAW10 byte stream to 4-pixel groups; RAW_UNPACKER_LENGTH_CHECK_EN adds line length checking
module raw_unpacker import mipi_pkg::*; #(
   parameter int NUM_LANES = 2,
   parameter int OUT_BITS = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_LANES*8-1:0]  image_data,
   input  logic [5:0]              image_data_type,
   input  logic                    image_data_enable,
   input  logic                    line_start,
`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
   input  logic [15:0]             word_count,
`endif
   output logic [4*OUT_BITS-1:0]   pixel,
   output logic                    pixel_valid,
   output logic                    type_err,
   output logic                    length_err
);
   logic [8*ACC_BYTES-1:0] acc, comb;
   logic [3:0] cnt, base_cnt, comb_cnt, grp;
   logic is8, is10, take, emit;
   logic [39:0] p10;
   logic [4*OUT_BITS-1:0] dec;
   always_comb begin
      is8 = image_data_type == DT_RAW8;
      is10 = image_data_type == DT_RAW10;
      take = image_data_enable && (is8 || is10);
      base_cnt = line_start ? 4'd0 : cnt;
      grp = is10 ? 4'd5 : 4'd4;
      comb = (line_start ? '0 : acc) | (take ? 64'(image_data) << (8*base_cnt) : '0);
      comb_cnt = base_cnt + (take ? 4'(NUM_LANES) : 4'd0);
      emit = (is8 || is10) && comb_cnt >= grp;
   end
   raw10_decode u_dec (.bytes(comb[39:0]), .pix(p10));
   // Left-align each sample in 12 bits, then keep the top OUT_BITS bits.
   for (genvar i = 0; i < 4; i++) begin : g_fmt
      assign dec[OUT_BITS*i +: OUT_BITS] = is10
         ? OUT_BITS'({p10[10*i +: 10], 2'b00} >> (12 - OUT_BITS))
         : OUT_BITS'({comb[8*i +: 8], 4'b0000} >> (12 - OUT_BITS));
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
         pixel <= '0;
         pixel_valid <= 1'b0;
         type_err <= 1'b0;
      end else begin
         pixel_valid <= emit;
         if (emit) pixel <= dec;
         acc <= emit ? comb >> (8*grp) : comb;
         cnt <= emit ? comb_cnt - grp : comb_cnt;
         if (image_data_enable && !(is8 || is10)) type_err <= 1'b1;
      end
   end
`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
   logic [15:0] bytes_seen, wc_q;
   logic [16:0] bsum;
   always_comb bsum = (line_start ? 17'd0 : {1'b0, bytes_seen}) + (image_data_enable ? 17'(NUM_LANES) : 17'd0);
   always_ff @(posedge clk) begin
      if (reset) begin
         bytes_seen <= '0;
         wc_q <= '0;
         length_err <= 1'b0;
      end else begin
         bytes_seen <= bsum[16] ? 16'hFFFF : bsum[15:0];
         if (line_start) wc_q <= word_count;
         if (line_start && bytes_seen != 16'd0 && bytes_seen != wc_q) length_err <= 1'b1;
      end
   end
`else
   assign length_err = 1'b0;
`endif
endmodule

// File: tb/tb_raw_unpacker.sv
// tb_raw_unpacker: vector table, directed corner sequences and queue-model random check of raw_unpacker
module tb_raw_unpacker;
   import mipi_pkg::*;
   logic clk = 1'b0;
   logic reset, ls, en2, en4;
   logic [5:0] dt;
   logic [15:0] d2;
   logic [31:0] d4;
   logic [39:0] pix2, pix4;
   logic v2, v4, te2, te4, le2, le4;
`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
   logic [15:0] wc;
`endif
   int cmp = 0, errs = 0;
   always #5 clk = ~clk;

   raw_unpacker #(.NUM_LANES(2), .OUT_BITS(10)) u2 (
      .clk(clk), .reset(reset), .image_data(d2), .image_data_type(dt),
      .image_data_enable(en2), .line_start(ls),
`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
      .word_count(wc),
`endif
      .pixel(pix2), .pixel_valid(v2), .type_err(te2), .length_err(le2));

   raw_unpacker #(.NUM_LANES(4), .OUT_BITS(10)) u4 (
      .clk(clk), .reset(reset), .image_data(d4), .image_data_type(dt),
      .image_data_enable(en4), .line_start(ls),
`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
      .word_count(wc),
`endif
      .pixel(pix4), .pixel_valid(v4), .type_err(te4), .length_err(le4));

   typedef struct {
      logic ls, en;
      logic [5:0] dt;
      logic [31:0] d;
      logic ev;
      logic [39:0] pix;
      logic [3:0] cnt;
      logic te;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      cmp++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1; ls = 1'b0; en2 = 1'b0; en4 = 1'b0; dt = DT_RAW8; d2 = '0; d4 = '0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   localparam logic [39:0] P8 = {10'h010, 10'h00C, 10'h008, 10'h004};
   localparam logic [39:0] PA = {10'h00C, 10'h008, 10'h005, 10'h000};
   localparam logic [39:0] PB = {10'h020, 10'h01C, 10'h01A, 10'h015};

   initial begin
      byte_t q[$];
      logic [39:0] ep;
      logic ev, ok, mterr;
      int nv, g;
      tv[0] = '{1'b1, 1'b1, DT_RAW8,  32'h04030201, 1'b1, P8, 4'd0, 1'b0};
      tv[1] = '{1'b0, 1'b1, DT_RAW8,  32'h04030201, 1'b1, P8, 4'd0, 1'b0};
      tv[2] = '{1'b0, 1'b1, DT_RAW8,  32'h04030201, 1'b1, P8, 4'd0, 1'b0};
      tv[3] = '{1'b1, 1'b1, DT_RAW10, 32'h03020100, 1'b0, P8, 4'd4, 1'b0};
      tv[4] = '{1'b0, 1'b1, DT_RAW10, 32'h07060504, 1'b1, PA, 4'd3, 1'b0};
      tv[5] = '{1'b0, 1'b1, DT_RAW10, 32'h0B0A0908, 1'b1, PB, 4'd2, 1'b0};
      tv[6] = '{1'b0, 1'b1, 6'h2C,    32'hFFFFFFFF, 1'b0, PB, 4'd2, 1'b1};
      tv[7] = '{1'b0, 1'b0, DT_RAW10, 32'h00000000, 1'b0, PB, 4'd2, 1'b1};
`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
      wc = 16'd10;
`endif
      do_reset;
      chk("reset pixel", 64'(pix4), 64'd0);
      chk("reset valid", 64'(v4), 64'd0);
      chk("reset type_err", 64'(te4), 64'd0);
      chk("reset length_err", 64'(le4), 64'd0);
      chk("reset cnt", 64'(u4.cnt), 64'd0);

      for (int i = 0; i < 8; i++) begin
         ls = tv[i].ls; en4 = tv[i].en; dt = tv[i].dt; d4 = tv[i].d;
         tick;
         chk($sformatf("vec%0d valid", i), 64'(v4), 64'(tv[i].ev));
         chk($sformatf("vec%0d pixel", i), 64'(pix4), 64'(tv[i].pix));
         chk($sformatf("vec%0d cnt", i), 64'(u4.cnt), 64'(tv[i].cnt));
         chk($sformatf("vec%0d type_err", i), 64'(te4), 64'(tv[i].te));
      end
      ls = 1'b0; en4 = 1'b0;
      tick;
      chk("type_err held", 64'(te4), 64'd1);
      do_reset;
      chk("type_err cleared", 64'(te4), 64'd0);

      dt = DT_RAW10; ls = 1'b1; en2 = 1'b1; d2 = 16'hBBAA;
      tick;
      chk("r10 beat1 valid", 64'(v2), 64'd0);
      ls = 1'b0; d2 = 16'hDDCC;
      tick;
      chk("r10 beat2 valid", 64'(v2), 64'd0);
      d2 = 16'h00E4;
      tick;
      chk("r10 beat3 valid", 64'(v2), 64'd1);
      chk("r10 pixel", 64'(pix2), 64'({10'h377, 10'h332, 10'h2ED, 10'h2A8}));
      chk("r10 cnt", 64'(u2.cnt), 64'd1);
      d2 = 16'h2211;
      tick;
      chk("r10 beat4 valid", 64'(v2), 64'd0);
      chk("r10 beat4 cnt", 64'(u2.cnt), 64'd3);
      ls = 1'b1; dt = DT_RAW8; d2 = 16'h4433;
      tick;
      chk("ls flush valid", 64'(v2), 64'd0);
      chk("ls flush cnt", 64'(u2.cnt), 64'd2);
      ls = 1'b0; en2 = 1'b0;

      do_reset;
      dt = DT_RAW10; nv = 0;
      for (int b = 0; b < 10; b++) begin
         ls = (b == 0); en4 = 1'b1; d4 = $urandom;
         tick;
         if (v4) nv++;
      end
      ls = 1'b0; en4 = 1'b0;
      chk("r10 40B groups", 64'(nv), 64'd8);
      chk("r10 40B cnt", 64'(u4.cnt), 64'd0);

      do_reset;
      mterr = 1'b0;
      for (int c = 0; c < 400; c++) begin
         ls = (c == 0) || ($urandom_range(0, 15) == 0);
         if (ls) dt = ($urandom_range(0, 19) == 0) ? 6'h2C : ($urandom_range(0, 1) ? DT_RAW10 : DT_RAW8);
         en4 = $urandom_range(0, 3) != 0;
         d4 = $urandom;
         if (ls) q.delete();
         ok = (dt == DT_RAW8) || (dt == DT_RAW10);
         if (en4 && ok) for (int k = 0; k < 4; k++) q.push_back(d4[8*k +: 8]);
         if (en4 && !ok) mterr = 1'b1;
         g = (dt == DT_RAW10) ? 5 : 4;
         ev = ok && (q.size() >= g);
         ep = '0;
         if (ev) begin
            for (int i = 0; i < 4; i++)
               ep[10*i +: 10] = (dt == DT_RAW10) ? {q[i], q[4][2*i +: 2]} : {q[i], 2'b00};
            for (int i = 0; i < g; i++) void'(q.pop_front());
         end
         tick;
         chk($sformatf("rnd%0d valid", c), 64'(v4), 64'(ev));
         if (ev) chk($sformatf("rnd%0d pixel", c), 64'(pix4), 64'(ep));
         chk($sformatf("rnd%0d cnt", c), 64'(u4.cnt), 64'(q.size()));
         chk($sformatf("rnd%0d type_err", c), 64'(te4), 64'(mterr));
      end
      ls = 1'b0; en4 = 1'b0;

`ifdef RAW_UNPACKER_LENGTH_CHECK_EN
      do_reset;
      wc = 16'd10; dt = DT_RAW8; en2 = 1'b1;
      for (int b = 0; b < 5; b++) begin
         ls = (b == 0); d2 = 16'(b);
         tick;
      end
      en2 = 1'b0; ls = 1'b1;
      tick;
      ls = 1'b0;
      chk("len 10 ok", 64'(le2), 64'd0);
      en2 = 1'b1;
      for (int b = 0; b < 4; b++) tick;
      en2 = 1'b0; ls = 1'b1;
      tick;
      ls = 1'b0;
      tick;
      chk("len 8 err", 64'(le2), 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
